// File: rtl/bsram_adapter_pkg.sv
// Shared encodings for the BSRAM request adapter: access sizes, FSM states, byte-enable helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package bsram_adapter_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_DATA = 2'd1,
        ST_RESP      = 2'd2
    } state_t;

    // Lane mask for an access of the given size starting at byte offset off.
    // Half accesses always start on an even byte; word covers all lanes.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << {off[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/bsram_load_align.sv
// Shifts the addressed lane of a BSRAM word down to bit 0 and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none; result follows inputs.
// Ports: read_data (raw word), offset (byte lane), size (SZ_*), zero_ext (1=zero, 0=sign) -> result.
module bsram_load_align
    import bsram_adapter_pkg::*;
(
    input  logic [31:0] read_data,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    output logic [31:0] result
);

    logic [31:0] lane;

    always_comb begin
        lane   = read_data >> {offset, 3'b000};
        result = lane;
        case (size)
            SZ_BYTE: result = {{24{~zero_ext & lane[7]}}, lane[7:0]};
            SZ_HALF: result = {{16{~zero_ext & lane[15]}}, lane[15:0]};
            default: result = lane;
        endcase
    end

endmodule

// File: rtl/bsram_req_adapter.sv
// Converts byte-addressed load/store requests into BSRAM word/byte-enable accesses and aligned responses.
// Latency: store/error response 1 cycle after accept, load response 2 cycles after accept.
// Backpressure: one request in flight; req_ready low until the response is taken (resp_valid & resp_ready).
// Ports: req_* request channel, resp_* response channel, read*/write* drive BSRAM_byte_en directly.
// Optional: define BSRAM_REQ_ADAPTER_ERR_EN to reject reserved-size and misaligned half/word requests.
module bsram_req_adapter
    import bsram_adapter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH+1:0] req_address,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_write,
    output logic                  resp_error,
    output logic                  readEnable,
    output logic [ADDR_WIDTH-1:0] readAddress,
    input  logic [DATA_WIDTH-1:0] readData,
    output logic                  writeEnable,
    output logic [3:0]            writeByteEnable,
    output logic [ADDR_WIDTH-1:0] writeAddress,
    output logic [DATA_WIDTH-1:0] writeData
);

    state_t      state, state_nxt;
    logic        accept;
    logic        err;
    logic [1:0]  size_n;
    logic [1:0]  offset_n;
    logic [1:0]  offset_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] load_result;

    // Request decode. Without error checking, reserved size behaves as word and
    // half/word accesses are forced onto their natural boundary.
    always_comb begin
`ifdef BSRAM_REQ_ADAPTER_ERR_EN
        err = (req_size == SZ_RSVD)
            | ((req_size == SZ_HALF) & req_address[0])
            | ((req_size == SZ_WORD) & (req_address[1:0] != 2'b00));
`else
        err = 1'b0;
`endif
        size_n = (req_size == SZ_RSVD) ? SZ_WORD : req_size;
        case (size_n)
            SZ_BYTE: offset_n = req_address[1:0];
            SZ_HALF: offset_n = {req_address[1], 1'b0};
            default: offset_n = 2'b00;
        endcase
    end

    assign accept = req_valid & req_ready;

    // BSRAM drive: the access happens on the accept edge itself.
    always_comb begin
        readAddress     = req_address[ADDR_WIDTH+1:2];
        writeAddress    = req_address[ADDR_WIDTH+1:2];
        writeEnable     = accept & req_write & ~err;
        readEnable      = accept & ~req_write & ~err;
        writeByteEnable = writeEnable ? byte_en(size_n, offset_n) : 4'b0000;
        case (size_n)
            SZ_BYTE: writeData = {4{req_wdata[7:0]}};
            SZ_HALF: writeData = {2{req_wdata[15:0]}};
            default: writeData = req_wdata;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = (req_write | err) ? ST_RESP : ST_LOAD_DATA;
            end
            ST_LOAD_DATA: state_nxt = ST_RESP;
            ST_RESP: begin
                if (resp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs. resp_valid decodes the state register so it falls with reset.
    always_comb begin
        req_ready  = (state == ST_IDLE);
        resp_valid = (state == ST_RESP);
    end

    bsram_load_align u_align (
        .read_data (readData),
        .offset    (offset_q),
        .size      (size_q),
        .zero_ext  (unsigned_q),
        .result    (load_result)
    );

    // Response payload: set on accept, load data filled in one cycle later,
    // otherwise untouched so it holds steady while the consumer stalls.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            offset_q   <= 2'b00;
            size_q     <= SZ_BYTE;
            unsigned_q <= 1'b0;
            resp_rdata <= '0;
            resp_write <= 1'b0;
            resp_error <= 1'b0;
        end else if (accept) begin
            offset_q   <= offset_n;
            size_q     <= size_n;
            unsigned_q <= req_unsigned;
            resp_rdata <= '0;
            resp_write <= req_write;
            resp_error <= err;
        end else if (state == ST_LOAD_DATA) begin
            resp_rdata <= load_result;
        end
    end

endmodule

// File: tb/tb_bsram_req_adapter.sv
// Directed table of load/store vectors against the adapter with a behavioural byte-enable BSRAM.
// Latency: checks 1-cycle store/error and 2-cycle load response timing.
// Backpressure: exercises stalled responses and reset in mid-transaction.
module tb_bsram_req_adapter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [9:0]  req_address;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_write;
    logic        resp_error;
    logic        readEnable;
    logic [7:0]  readAddress;
    logic [31:0] readData;
    logic        writeEnable;
    logic [3:0]  writeByteEnable;
    logic [7:0]  writeAddress;
    logic [31:0] writeData;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    bsram_req_adapter dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_address     (req_address),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_rdata      (resp_rdata),
        .resp_write      (resp_write),
        .resp_error      (resp_error),
        .readEnable      (readEnable),
        .readAddress     (readAddress),
        .readData        (readData),
        .writeEnable     (writeEnable),
        .writeByteEnable (writeByteEnable),
        .writeAddress    (writeAddress),
        .writeData       (writeData)
    );

    // Behavioural BSRAM: byte-masked write, registered read.
    logic [31:0] mem [0:255];
    always @(posedge clock) begin
        if (writeEnable) begin
            for (int b = 0; b < 4; b++)
                if (writeByteEnable[b]) mem[writeAddress][8*b +: 8] <= writeData[8*b +: 8];
        end
        if (readEnable) readData <= mem[readAddress];
    end

    typedef struct {
        logic        wr;
        logic [9:0]  addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic        exp_re;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic wr, logic [9:0] a, logic [1:0] sz, logic u, logic [31:0] wd,
                                logic re, logic we, logic [3:0] be, logic [31:0] ewd,
                                logic [31:0] rd, logic er);
        vec_t v;
        v.wr = wr; v.addr = a; v.size = sz; v.uns = u; v.wdata = wd;
        v.exp_re = re; v.exp_we = we; v.exp_be = be; v.exp_wdata = ewd;
        v.exp_rdata = rd; v.exp_err = er;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic wait_resp(input int idx, output int cyc);
        cyc = 1;
        while (resp_valid !== 1'b1 && cyc < 8) begin
            @(negedge clock);
            cyc++;
        end
        if (resp_valid !== 1'b1) chk("resp_timeout", idx, 32'(resp_valid), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        int exp_lat;
        @(negedge clock);
        req_valid    = 1'b1;
        req_write    = v.wr;
        req_address  = v.addr;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_wdata    = v.wdata;
        #1;
        chk("req_ready", idx, 32'(req_ready), 32'd1);
        chk("readEnable", idx, 32'(readEnable), 32'(v.exp_re));
        chk("writeEnable", idx, 32'(writeEnable), 32'(v.exp_we));
        chk("writeByteEnable", idx, 32'(writeByteEnable), 32'(v.exp_be));
        if (v.exp_we) chk("writeData", idx, writeData, v.exp_wdata);
        if (v.exp_we) chk("writeAddress", idx, 32'(writeAddress), 32'(v.addr[9:2]));
        if (v.exp_re) chk("readAddress", idx, 32'(readAddress), 32'(v.addr[9:2]));
        @(negedge clock);
        req_valid = 1'b0;
        wait_resp(idx, cyc);
        exp_lat = (v.wr || v.exp_err) ? 1 : 2;
        chk("latency", idx, 32'(cyc), 32'(exp_lat));
        chk("resp_rdata", idx, resp_rdata, v.exp_rdata);
        chk("resp_write", idx, 32'(resp_write), 32'(v.wr));
        chk("resp_error", idx, 32'(resp_error), 32'(v.exp_err));
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        chk("resp_valid_drop", idx, 32'(resp_valid), 32'd0);
        chk("req_ready_back", idx, 32'(req_ready), 32'd1);
    endtask

    task automatic issue_load(input logic [9:0] a);
        @(negedge clock);
        req_valid    = 1'b1;
        req_write    = 1'b0;
        req_address  = a;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_wdata    = '0;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [31:0] held;

        // wr, addr, size, uns, wdata, re, we, be, wdata_exp, rdata_exp, err
        vecs.push_back(mk(1, 10'h08, 2'b10, 0, 32'hAAAA8888, 0, 1, 4'b1111, 32'hAAAA8888, 32'h0, 0));
        vecs.push_back(mk(0, 10'h08, 2'b10, 0, 32'h0,        1, 0, 4'b0000, 32'h0, 32'hAAAA8888, 0));
        vecs.push_back(mk(0, 10'h0B, 2'b00, 0, 32'h0,        1, 0, 4'b0000, 32'h0, 32'hFFFFFFAA, 0));
        vecs.push_back(mk(0, 10'h0B, 2'b00, 1, 32'h0,        1, 0, 4'b0000, 32'h0, 32'h000000AA, 0));
        vecs.push_back(mk(0, 10'h0A, 2'b01, 0, 32'h0,        1, 0, 4'b0000, 32'h0, 32'hFFFFAAAA, 0));
        vecs.push_back(mk(0, 10'h08, 2'b01, 1, 32'h0,        1, 0, 4'b0000, 32'h0, 32'h00008888, 0));
        vecs.push_back(mk(1, 10'h08, 2'b01, 0, 32'h00000064, 0, 1, 4'b0011, 32'h00640064, 32'h0, 0));
        vecs.push_back(mk(0, 10'h08, 2'b10, 0, 32'h0,        1, 0, 4'b0000, 32'h0, 32'hAAAA0064, 0));
        vecs.push_back(mk(1, 10'h0C, 2'b10, 0, 32'h00000000, 0, 1, 4'b1111, 32'h00000000, 32'h0, 0));
        vecs.push_back(mk(1, 10'h0D, 2'b00, 0, 32'h1234565A, 0, 1, 4'b0010, 32'h5A5A5A5A, 32'h0, 0));
        vecs.push_back(mk(0, 10'h0C, 2'b10, 0, 32'h0,        1, 0, 4'b0000, 32'h0, 32'h00005A00, 0));
        vecs.push_back(mk(0, 10'h0D, 2'b00, 0, 32'h0,        1, 0, 4'b0000, 32'h0, 32'h0000005A, 0));
        vecs.push_back(mk(1, 10'h0E, 2'b01, 0, 32'h1111BEEF, 0, 1, 4'b1100, 32'hBEEFBEEF, 32'h0, 0));
        vecs.push_back(mk(0, 10'h0E, 2'b01, 0, 32'h0,        1, 0, 4'b0000, 32'h0, 32'hFFFFBEEF, 0));
        vecs.push_back(mk(0, 10'h0F, 2'b00, 1, 32'h0,        1, 0, 4'b0000, 32'h0, 32'h000000BE, 0));
`ifdef BSRAM_REQ_ADAPTER_ERR_EN
        vecs.push_back(mk(0, 10'h09, 2'b10, 0, 32'h0,        0, 0, 4'b0000, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 10'h08, 2'b11, 0, 32'h0,        0, 0, 4'b0000, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 10'h09, 2'b01, 0, 32'h0,        0, 0, 4'b0000, 32'h0, 32'h0, 1));
        vecs.push_back(mk(1, 10'h0D, 2'b01, 0, 32'h0000FFFF, 0, 0, 4'b0000, 32'h0, 32'h0, 1));
`else
        vecs.push_back(mk(0, 10'h09, 2'b10, 0, 32'h0,        1, 0, 4'b0000, 32'h0, 32'hAAAA0064, 0));
        vecs.push_back(mk(0, 10'h08, 2'b11, 0, 32'h0,        1, 0, 4'b0000, 32'h0, 32'hAAAA0064, 0));
        vecs.push_back(mk(0, 10'h09, 2'b01, 0, 32'h0,        1, 0, 4'b0000, 32'h0, 32'h00000064, 0));
`endif

        reset        = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_address  = '0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_wdata    = '0;
        resp_ready   = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_resp_valid", 0, 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", 0, resp_rdata, 32'd0);
        chk("rst_resp_write", 0, 32'(resp_write), 32'd0);
        chk("rst_resp_error", 0, 32'(resp_error), 32'd0);
        chk("rst_req_ready", 0, 32'(req_ready), 32'd1);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Stalled response: payload must hold while resp_ready is low.
        issue_load(10'h08);
        wait_resp(100, cyc);
        held = resp_rdata;
        chk("bp_rdata", 100, held, 32'hAAAA0064);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("bp_resp_valid", 100 + k, 32'(resp_valid), 32'd1);
            chk("bp_resp_rdata", 100 + k, resp_rdata, held);
            chk("bp_resp_write", 100 + k, 32'(resp_write), 32'd0);
            chk("bp_req_ready", 100 + k, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        chk("bp_release_valid", 103, 32'(resp_valid), 32'd0);
        chk("bp_release_ready", 103, 32'(req_ready), 32'd1);

        // Reset while the load is waiting for BSRAM data.
        issue_load(10'h0C);
        chk("ld_state_ready", 200, 32'(req_ready), 32'd0);
        chk("ld_state_valid", 200, 32'(resp_valid), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_ld_valid", 200, 32'(resp_valid), 32'd0);
        chk("rst_ld_ready", 200, 32'(req_ready), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("post_rst_valid", 201 + k, 32'(resp_valid), 32'd0);
            chk("post_rst_ready", 201 + k, 32'(req_ready), 32'd1);
        end

        // Reset while a response is being presented drops resp_valid at once.
        issue_load(10'h0C);
        wait_resp(300, cyc);
        chk("resp_pre_rst", 300, resp_rdata, 32'hBEEF5A00);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_resp_async", 300, 32'(resp_valid), 32'd0);
        chk("rst_resp_clear", 300, resp_rdata, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Clean operation after reset; earlier stores survive.
        run_vec(mk(0, 10'h0C, 2'b10, 0, 32'h0, 1, 0, 4'b0000, 32'h0, 32'hBEEF5A00, 0), 400);
        run_vec(mk(0, 10'h08, 2'b10, 0, 32'h0, 1, 0, 4'b0000, 32'h0, 32'hAAAA0064, 0), 401);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/bsram_req_adapter.md
Name: bsram_req_adapter

Overview:
- Request-side front end that sits directly upstream of BSRAM_byte_en.
- Accepts byte-addressed load/store requests (byte, half, word) over a valid/ready handshake.
- Converts each request into BSRAM word-address, byte-enable and replicated-data accesses.
- Returns aligned, sign- or zero-extended load data and store acknowledgements over a valid/ready response channel.

Parameters:
- DATA_WIDTH, 32, BSRAM word width; only 32 is supported.
- ADDR_WIDTH, 8, BSRAM word-address width; byte address width is ADDR_WIDTH+2.

Ports:
- clock  input  1  system clock; all state on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 resets).
- req_valid  input  1  request present.
- req_ready  output  1  adapter can accept a request.
- req_write  input  1  1=store, 0=load.
- req_address  input  ADDR_WIDTH+2  byte address.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer takes the response.
- resp_rdata  output  32  aligned load data; 0 for stores and errors.
- resp_write  output  1  response belongs to a store.
- resp_error  output  1  request was rejected.
- readEnable  output  1  to BSRAM.
- readAddress  output  ADDR_WIDTH  to BSRAM.
- readData  input  32  from BSRAM; valid the cycle after a read edge.
- writeEnable  output  1  to BSRAM.
- writeByteEnable  output  4  to BSRAM.
- writeAddress  output  ADDR_WIDTH  to BSRAM.
- writeData  output  32  to BSRAM.

Behaviour:
- States: IDLE, LOAD_DATA, RESP.
- Reset state: IDLE; resp_valid=0, resp_rdata=0, resp_write=0, resp_error=0.
- Handshakes:
  - req_ready = (state==IDLE). Accept = req_valid & req_ready.
  - One request in flight at a time.
- BSRAM drive (combinational):
  - readAddress = writeAddress = req_address[ADDR_WIDTH+1:2].
  - writeEnable = accept & req_write & ~err.
  - readEnable = accept & ~req_write & ~err.
  - writeByteEnable = 0 unless writeEnable is 1.
- Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << {addr[1],1'b0}.
  - word: 4'b1111.
- writeData: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Store path (write lands on the accept edge):
  - IDLE -> RESP with resp_write=1, resp_error=0, resp_rdata=0.
  - Latency 1 cycle from the accept edge to resp_valid.
- Load path:
  - IDLE -> LOAD_DATA; offset, size and unsigned are registered.
  - In LOAD_DATA: lane = readData >> (8*offset); extract [7:0] or [15:0]; extend per the registered unsigned flag; capture into resp_rdata.
  - LOAD_DATA -> RESP.
  - Latency 2 cycles from the accept edge to resp_valid.
- Error path: err request -> RESP with resp_error=1, resp_rdata=0, no BSRAM access; latency 1.
- RESP:
  - resp_valid=1.
  - All resp_* fields hold stable until resp_valid & resp_ready.
  - Then -> IDLE; req_ready rises the following cycle.
- reset asserted in any state:
  - Immediate return to IDLE; the in-flight response is discarded; resp_valid drops asynchronously.
  - A store already written stays written.

Optional Feature:
- BSRAM_REQ_ADAPTER_ERR_EN defined:
  - err = (size==11) | (half & addr[0]) | (word & addr[1:0]!=0).
  - Errored requests do no BSRAM access and return resp_error=1.
- Undefined:
  - err=0 always.
  - size 11 treated as word.
  - Half ignores addr[0]; word ignores addr[1:0] (forced alignment).
  - resp_error tied 0.

Decomposition:
- Package bsram_adapter_pkg:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - state encodings;
  - byte-enable function.
- One sub-module: bsram_load_align, purely combinational: readData, offset, size, unsigned -> 32-bit extended result.

Test Plan:
- Word store 0x08 = AAAA8888, then word load 0x08.
  - Store: writeEnable=1, writeAddress=2, writeByteEnable=1111 in the accept cycle; resp_valid one cycle later with resp_write=1.
  - Load: resp_rdata=AAAA8888 two cycles after accept.
- Half store 0x08 = 0x0064.
  - writeByteEnable=0011, writeData=00640064.
  - Subsequent word load 0x08 -> AAAA0064.
- Loads from word 2 holding AAAA8888:
  - byte signed 0x0B -> FFFFFFAA;
  - byte unsigned 0x0B -> 000000AA;
  - half signed 0x0A -> FFFFAAAA;
  - half unsigned 0x08 -> 00008888.
- Backpressure: resp_ready=0 for 3 cycles after a load.
  - resp_valid, resp_rdata and resp_write stay stable; req_ready=0 throughout.
  - Accepted cleanly on the 4th cycle.
- Word load at 0x09:
  - With BSRAM_REQ_ADAPTER_ERR_EN: resp_error=1, resp_rdata=0, readEnable never 1.
  - Without: returns word 2 contents, resp_error=0.
- reset driven low during LOAD_DATA.
  - resp_valid=0 immediately.
  - After release, req_ready=1 and no spurious response appears.
